// File: rtl/regfile_sb_if.sv
// Bus bundle between the core's decode/writeback logic and the register file.
// Flat read vectors: port i lives at [i*AW +: AW] / [i*XLEN +: XLEN].
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wa_en;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                mark_en;
  logic [AW-1:0]       mark_addr;
  logic [CW-1:0]       pend_cnt;
  logic                any_pend;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, mark_en, mark_addr,
    input  rd_data, rd_busy, pend_cnt, any_pend
  );
  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, mark_en, mark_addr,
    output rd_data, rd_busy, pend_cnt, any_pend
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-write-port register file with load scoreboard and same-cycle write forwarding.
// Port A (ALU) beats port B (load return) on data; a new mark beats a same-cycle clear.
module regfile_sb_rdport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                        en_i,
  input  logic [AW-1:0]               addr_i,
  input  logic [NREGS-1:0][XLEN-1:0]  regs_i,
  input  logic [NREGS-1:0]            pend_i,
  input  logic                        wa_en_i,
  input  logic [AW-1:0]               wa_addr_i,
  input  logic [XLEN-1:0]             wa_data_i,
  input  logic                        wb_en_i,
  input  logic [AW-1:0]               wb_addr_i,
  input  logic [XLEN-1:0]             wb_data_i,
  input  logic                        mark_en_i,
  input  logic [AW-1:0]               mark_addr_i,
  output logic [XLEN-1:0]             data_o,
  output logic                        busy_o
);
  logic zero, wa_hit, wb_hit;

  always_comb begin
    zero   = (ZERO_REG != 0) && (addr_i == '0);
    wa_hit = wa_en_i && (wa_addr_i == addr_i);
    wb_hit = wb_en_i && (wb_addr_i == addr_i);
    data_o = '0;
    busy_o = 1'b0;
    if (en_i && !zero) begin
      if (wa_hit)      data_o = wa_data_i;
      else if (wb_hit) data_o = wb_data_i;
      else             data_o = regs_i[addr_i];
      // returning load un-busies now; a fresh mark busies now
      busy_o = (pend_i[addr_i] && !wb_hit) || (mark_en_i && (mark_addr_i == addr_i));
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           pend_q, pend_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       wa_ok, wb_ok, mk_ok, inc, dec;
  logic [NRD-1:0][XLEN-1:0]   rd_data_w;
  logic [NRD-1:0]             rd_busy_w;

  always_comb begin
    wa_ok  = bus.wa_en   && !((ZERO_REG != 0) && (bus.wa_addr   == '0));
    wb_ok  = bus.wb_en   && !((ZERO_REG != 0) && (bus.wb_addr   == '0));
    mk_ok  = bus.mark_en && !((ZERO_REG != 0) && (bus.mark_addr == '0));
    regs_d = regs_q;
    if (wb_ok) regs_d[bus.wb_addr] = bus.wb_data;
    if (wa_ok) regs_d[bus.wa_addr] = bus.wa_data;
    pend_d = pend_q;
    if (wb_ok) pend_d[bus.wb_addr]   = 1'b0;
    if (mk_ok) pend_d[bus.mark_addr] = 1'b1;
    // count only real bit flips so cnt_q always equals popcount(pend_q)
    inc   = mk_ok && !pend_q[bus.mark_addr];
    dec   = wb_ok && pend_q[bus.wb_addr] && !(mk_ok && (bus.mark_addr == bus.wb_addr));
    cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_rd (
      .en_i        (!reset),
      .addr_i      (bus.rd_addr[i*AW +: AW]),
      .regs_i      (regs_q),
      .pend_i      (pend_q),
      .wa_en_i     (bus.wa_en),
      .wa_addr_i   (bus.wa_addr),
      .wa_data_i   (bus.wa_data),
      .wb_en_i     (bus.wb_en),
      .wb_addr_i   (bus.wb_addr),
      .wb_data_i   (bus.wb_data),
      .mark_en_i   (bus.mark_en),
      .mark_addr_i (bus.mark_addr),
      .data_o      (rd_data_w[i]),
      .busy_o      (rd_busy_w[i])
    );
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_busy  = rd_busy_w;
  assign bus.pend_cnt = cnt_q;
  assign bus.any_pend = |cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb (NRD=4, NREGS=64): directed scenarios with literal
// expectations plus a per-cycle comparison against an array-based model.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 64;
  localparam int NRD   = 4;
  localparam int AW    = $clog2(NREGS);

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   cmp_on = 1'b0;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference: architectural register contents and set of pending registers
  logic [XLEN-1:0]  mregs [NREGS];
  logic [NREGS-1:0] mpend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) mregs[r] <= '0;
      mpend <= '0;
    end else begin
      if (bus.wb_en && bus.wb_addr != 0) mregs[bus.wb_addr] <= bus.wb_data;
      if (bus.wa_en && bus.wa_addr != 0) mregs[bus.wa_addr] <= bus.wa_data;
      if (bus.wb_en && bus.wb_addr != 0) mpend[bus.wb_addr] <= 1'b0;
      if (bus.mark_en && bus.mark_addr != 0) mpend[bus.mark_addr] <= 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(int a);
    if (reset || a == 0) return '0;
    if (bus.wa_en && bus.wa_addr == a) return bus.wa_data;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(int a);
    if (reset || a == 0) return 1'b0;
    if (bus.mark_en && bus.mark_addr == a) return 1'b1;
    if (bus.wb_en && bus.wb_addr == a) return 1'b0;
    return mpend[a];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < NRD; i++) begin
        int a;
        a = int'(bus.rd_addr[i*AW +: AW]);
        chk($sformatf("m_rd_data%0d", i), 64'(bus.rd_data[i*XLEN +: XLEN]), 64'(exp_data(a)));
        chk($sformatf("m_rd_busy%0d", i), 64'(bus.rd_busy[i]), 64'(exp_busy(a)));
      end
      chk("m_pend_cnt", 64'(bus.pend_cnt), 64'($countones(mpend)));
      chk("m_any_pend", 64'(bus.any_pend), 64'(mpend != '0));
    end
  end

  function automatic logic [XLEN-1:0] rd(int p);
    return bus.rd_data[p*XLEN +: XLEN];
  endfunction

  task automatic set_rd(int p, int a);
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    bus.wa_en = 0; bus.wb_en = 0; bus.mark_en = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wa(int a, logic [XLEN-1:0] d);
    bus.wa_en = 1; bus.wa_addr = AW'(a); bus.wa_data = d;
  endtask

  task automatic wb(int a, logic [XLEN-1:0] d);
    bus.wb_en = 1; bus.wb_addr = AW'(a); bus.wb_data = d;
  endtask

  task automatic mark(int a);
    bus.mark_en = 1; bus.mark_addr = AW'(a);
  endtask

  initial begin
    bus.rd_addr = '0; bus.wa_addr = '0; bus.wa_data = '0; bus.wb_addr = '0;
    bus.wb_data = '0; bus.mark_addr = '0;
    idle();
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    cmp_on = 1;
    set_rd(0, 5);
    #1;
    chk("rst_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("rst_data0", 64'(rd(0)), 64'd0);

    // forwarding then persistence
    wa(5, 32'hDEADBEEF); #1;
    chk("byp_same", 64'(rd(0)), 64'hDEADBEEF);
    step(); idle(); #1;
    chk("byp_hold", 64'(rd(0)), 64'hDEADBEEF);

    // scoreboard: 3, 4, 3 again
    mark(3); step(); mark(4); step(); mark(3); step(); idle();
    chk("sb_cnt2", 64'(bus.pend_cnt), 64'd2);
    set_rd(1, 3); #1;
    chk("sb_busy1", 64'(bus.rd_busy[1]), 64'd1);
    wb(3, 32'h55); #1;
    chk("sb_wb_busy", 64'(bus.rd_busy[1]), 64'd0);
    chk("sb_wb_data", 64'(rd(1)), 64'h55);
    step(); idle(); #1;
    chk("sb_cnt1", 64'(bus.pend_cnt), 64'd1);

    // collision on reg 7
    mark(7); step(); idle();
    chk("col_cnt_pre", 64'(bus.pend_cnt), 64'd2);
    set_rd(0, 7); wa(7, 32'h11); wb(7, 32'h22); #1;
    chk("col_fwd", 64'(rd(0)), 64'h11);
    step(); idle(); #1;
    chk("col_reg", 64'(rd(0)), 64'h11);
    chk("col_cnt", 64'(bus.pend_cnt), 64'd1);
    chk("col_busy", 64'(bus.rd_busy[0]), 64'd0);

    // mark and return together on reg 9
    mark(9); step(); idle();
    chk("mr_cnt_pre", 64'(bus.pend_cnt), 64'd2);
    set_rd(0, 9); mark(9); wb(9, 32'h99);
    step(); idle(); #1;
    chk("mr_cnt", 64'(bus.pend_cnt), 64'd2);
    chk("mr_busy", 64'(bus.rd_busy[0]), 64'd1);
    chk("mr_data", 64'(rd(0)), 64'h99);

    // register 0
    set_rd(0, 0); wa(0, 32'hFFFF_FFFF); mark(0); #1;
    chk("z_data", 64'(rd(0)), 64'd0);
    chk("z_busy", 64'(bus.rd_busy[0]), 64'd0);
    step(); idle(); #1;
    chk("z_cnt", 64'(bus.pend_cnt), 64'd2);
    chk("z_data_after", 64'(rd(0)), 64'd0);

    // async reset with 3 loads outstanding
    mark(10); step(); idle();
    chk("ar_cnt_pre", 64'(bus.pend_cnt), 64'd3);
    set_rd(0, 9); set_rd(1, 4); set_rd(2, 10); set_rd(3, 5);
    #1 reset = 1;
    #1;
    for (int i = 0; i < NRD; i++) chk($sformatf("ar_data%0d", i), 64'(rd(i)), 64'd0);
    chk("ar_busy", 64'(bus.rd_busy), 64'd0);
    chk("ar_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("ar_any", 64'(bus.any_pend), 64'd0);
    step(); reset = 0;
    wb(4, 32'h44); step(); idle(); #1;
    chk("ar_wb_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("ar_wb_data", 64'(rd(1)), 64'h44);

    // random traffic on a narrow address window to provoke collisions
    for (int c = 0; c < 400; c++) begin
      bus.wa_en = 1'($urandom_range(0, 1)); bus.wa_addr = AW'($urandom_range(0, 15));
      bus.wa_data = $urandom;
      bus.wb_en = 1'($urandom_range(0, 1)); bus.wb_addr = AW'($urandom_range(0, 15));
      bus.wb_data = $urandom;
      bus.mark_en = 1'($urandom_range(0, 1)); bus.mark_addr = AW'($urandom_range(0, 15));
      for (int p = 0; p < NRD; p++) set_rd(p, int'($urandom_range(0, 15)));
      step();
    end
    idle(); step(); step();
    cmp_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
